sram_fifo_ctrl: RTL and testbench

Streaming FIFO controller that sits directly upstream of `unit_sram_dp` and drives its fabric-side ports. It turns a valid/ready push stream and a valid/ready pop stream into write-port and read-port transactions on the 32x512 dual-port macro, using the SRAM as FIFO storage. A small register skid FIFO absorbs the fixed SRAM read latency, so the pop side sustains one word per cycle under backpressure.

---
 rtl/sram_fifo_ctrl_pkg.sv | 20 ++
 rtl/sram_fifo_ctrl_if.sv | 38 +++
 rtl/sram_fifo_ctrl_skid.sv | 67 ++++++
 rtl/sram_fifo_ctrl.sv | 126 ++++++++++++
 tb/tb_sram_fifo_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_fifo_ctrl_pkg.sv
// sram_fifo_pkg: shared constants and helpers for the SRAM-backed stream FIFO.
//   SRAM_AW    : word-pointer width (512 words)
//   SRAM_DW    : data width
//   SRAM_BA_W  : bit-address width of the macro address ports
//   CONF_W32   : macro configuration code selecting 32-bit words
//   COUNT_W    : width of the occupancy counter
//   word_to_bitaddr() : word pointer -> macro bit address
package sram_fifo_pkg;
  localparam int SRAM_AW    = 9;
  localparam int SRAM_DW    = 32;
  localparam int SRAM_BA_W  = 14;
  localparam int SRAM_DEPTH = 1 << SRAM_AW;
  localparam int COUNT_W    = 10;
  localparam logic [2:0] CONF_W32 = 3'b101;

  // The macro is bit-addressed; a 32-bit word occupies 32 consecutive bits.
  function automatic logic [SRAM_BA_W-1:0] word_to_bitaddr(input logic [SRAM_AW-1:0] ptr);
    return {ptr, 5'b0};
  endfunction
endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// sram_fifo_ctrl_if: bundles the push stream, pop stream, occupancy and the
// fabric-side SRAM port signals of sram_fifo_ctrl.
//   slave  : view taken by the FIFO controller
//   master : view taken by the surrounding fabric / SRAM macro model
interface sram_fifo_ctrl_if;
  import sram_fifo_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [SRAM_DW-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SRAM_DW-1:0]   out_data;
  logic [COUNT_W-1:0]   count;
  logic [SRAM_DW-1:0]   sram_d_in;
  logic                 sram_csb;
  logic                 sram_web;
  logic                 sram_reb;
  logic [SRAM_BA_W-1:0] sram_addr_w;
  logic [SRAM_BA_W-1:0] sram_addr_r;
  logic [2:0]           sram_conf;
  logic                 sram_out_reg;
  logic [SRAM_DW-1:0]   sram_d_out;

  modport slave (
    input  in_valid, in_data, out_ready, sram_d_out,
    output in_ready, out_valid, out_data, count,
           sram_d_in, sram_csb, sram_web, sram_reb,
           sram_addr_w, sram_addr_r, sram_conf, sram_out_reg
  );

  modport master (
    output in_valid, in_data, out_ready, sram_d_out,
    input  in_ready, out_valid, out_data, count,
           sram_d_in, sram_csb, sram_web, sram_reb,
           sram_addr_w, sram_addr_r, sram_conf, sram_out_reg
  );
endinterface

// File: rtl/sram_fifo_ctrl_skid.sv
// sram_fifo_skid: small register FIFO that catches SRAM read data.
//   clk, rst      : clock, synchronous active-high reset
//   push_i/_data_i: write one entry (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   pop_data_o    : head entry
//   occ_o         : number of entries held
//   full_o/empty_o: occupancy flags
module sram_fifo_skid #(
  parameter  int DEPTH = 3,
  parameter  int DW    = 32,
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [DW-1:0]    push_data_i,
  input  logic             pop_i,
  output logic [DW-1:0]    pop_data_o,
  output logic [OCC_W-1:0] occ_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [DW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic             push_ok, pop_ok;
  logic [DEPTH-1:0] wr_en;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o    = (occ_q == '0);
  assign full_o     = (occ_q == OCC_W'(DEPTH));
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign occ_o      = occ_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push_ok && (wr_ptr_q == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      occ_q <= occ_q + OCC_W'(push_ok) - OCC_W'(pop_ok);
    end
  end

  // Storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) mem_q[i] <= push_data_i;
    end
  end
endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: turns a valid/ready push stream and pop stream into
// write/read transactions on a 32x512 dual-port SRAM used as FIFO storage.
// A skid FIFO of RD_LAT+1 entries hides the fixed SRAM read latency.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : push stream (in_*), pop stream (out_*), count, SRAM ports
// Parameters: RD_LAT (read latency, cycles), OUT_REG (macro output register).
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int RD_LAT  = 2,
  parameter bit OUT_REG = 1'b0
) (
  input logic            clk,
  input logic            rst,
  sram_fifo_ctrl_if.slave bus
);
  localparam int SKID_DEPTH = RD_LAT + 1;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

  logic [SRAM_AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [COUNT_W-1:0]   sram_words_q, sram_words_d, avail;
  logic                 pend_wr_q, pend_wr_d;
  logic [RD_LAT-1:0]    inflight_q, inflight_d;
  logic [SRAM_BA_W-1:0] addr_w_q, addr_w_d, addr_r_q, addr_r_d;
  logic [SRAM_DW-1:0]   d_in_q, d_in_d;
  logic [OCC_W-1:0]     infl_cnt, skid_occ;
  logic                 skid_full, skid_empty;
  logic                 push_fire, pop_fire, rd_issue;
  int                   credit_used;

  // Words that may be read this cycle: committed words plus last cycle's push,
  // which was written at the previous edge and is therefore safe to read now.
  assign avail     = sram_words_q + COUNT_W'(pend_wr_q);
  assign push_fire = bus.in_valid && bus.in_ready;
  assign pop_fire  = bus.out_valid && bus.out_ready;

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) infl_cnt = infl_cnt + OCC_W'(inflight_q[i]);
  end

  // Skid credit: every issued read owns a skid slot until it is popped. The
  // head leaving this cycle returns its slot immediately, which is what lets
  // RD_LAT+1 slots sustain one read per cycle.
  always_comb begin
    credit_used = int'(skid_occ) + int'(infl_cnt) - int'(pop_fire);
  end

  // The skid_full term is redundant with the credit check and only guards
  // against a future change to the credit arithmetic.
  assign rd_issue = !rst && (avail != '0) && (credit_used < SKID_DEPTH) &&
                    !(skid_full && !pop_fire);

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    addr_w_d = addr_w_q;
    addr_r_d = addr_r_q;
    d_in_d   = d_in_q;
    if (push_fire) begin
      wptr_d   = wptr_q + 1'b1;
      addr_w_d = word_to_bitaddr(wptr_q);
      d_in_d   = bus.in_data;
    end
    if (rd_issue) begin
      rptr_d   = rptr_q + 1'b1;
      addr_r_d = word_to_bitaddr(rptr_q);
    end
    sram_words_d = avail - COUNT_W'(rd_issue);
    pend_wr_d    = push_fire;
    inflight_d   = (inflight_q << 1) | RD_LAT'(rd_issue);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      sram_words_q <= '0;
      pend_wr_q    <= 1'b0;
      inflight_q   <= '0;
      addr_w_q     <= '0;
      addr_r_q     <= '0;
      d_in_q       <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      sram_words_q <= sram_words_d;
      pend_wr_q    <= pend_wr_d;
      inflight_q   <= inflight_d;
      addr_w_q     <= addr_w_d;
      addr_r_q     <= addr_r_d;
      d_in_q       <= d_in_d;
    end
  end

  // Reset clears inflight_q, so data returning for pre-reset reads is never
  // captured.
  sram_fifo_skid #(
    .DEPTH (SKID_DEPTH),
    .DW    (SRAM_DW)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q[RD_LAT-1]),
    .push_data_i (bus.sram_d_out),
    .pop_i       (pop_fire),
    .pop_data_o  (bus.out_data),
    .occ_o       (skid_occ),
    .full_o      (skid_full),
    .empty_o     (skid_empty)
  );

  // Address/data ports show the new value on an active cycle and hold the
  // previous one when idle.
  assign bus.in_ready     = !rst && (avail < COUNT_W'(SRAM_DEPTH));
  assign bus.out_valid    = !rst && !skid_empty;
  assign bus.count        = avail + COUNT_W'(infl_cnt) + COUNT_W'(skid_occ);
  assign bus.sram_web     = !push_fire;
  assign bus.sram_reb     = !rd_issue;
  assign bus.sram_csb     = bus.sram_web & bus.sram_reb;
  assign bus.sram_addr_w  = addr_w_d;
  assign bus.sram_addr_r  = addr_r_d;
  assign bus.sram_d_in    = d_in_d;
  assign bus.sram_conf    = CONF_W32;
  assign bus.sram_out_reg = OUT_REG;
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed and randomized checks of sram_fifo_ctrl against
// a behavioural model of the dual-port SRAM with RD_LAT read latency.
module tb_sram_fifo_ctrl;
  import sram_fifo_pkg::*;

  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  sram_fifo_ctrl_if bus();

  sram_fifo_ctrl #(.RD_LAT(RD_LAT), .OUT_REG(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM model: write at the edge, read data appears RD_LAT edges after issue.
  logic [31:0] mem [512];
  logic [31:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (!bus.sram_csb && !bus.sram_web) mem[bus.sram_addr_w[13:5]] <= bus.sram_d_in;
    if (!bus.sram_csb && !bus.sram_reb) rd_pipe[0] <= mem[bus.sram_addr_r[13:5]];
    else                                rd_pipe[0] <= 32'h0BAD_F00D;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.sram_d_out = rd_pipe[RD_LAT-1];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else passed++;
      checks++; if (bus.sram_web !== 1'b1) $display("FAIL reset_web: got %b want 1", bus.sram_web); else passed++;
    end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.count !== 10'd0) $display("FAIL post_reset_count: got %0d want 0", bus.count); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL post_reset_out_valid: got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); else passed++;
    checks++; if ({bus.sram_csb, bus.sram_reb} !== 2'b11) $display("FAIL post_reset_csb_reb: got %b want 11", {bus.sram_csb, bus.sram_reb}); else passed++;
    checks++; if (bus.sram_conf !== 3'b101) $display("FAIL conf: got %b want 101", bus.sram_conf); else passed++;
    checks++; if (bus.sram_out_reg !== 1'b0) $display("FAIL out_reg: got %b want 0", bus.sram_out_reg); else passed++;
  endtask

  task automatic test_single();
    @(negedge clk);                       // cycle 0
    bus.in_valid = 1'b1; bus.in_data = 32'hDEADBEEF; bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.sram_addr_w !== 14'h0) $display("FAIL single_addr_w: got %h want 0000", bus.sram_addr_w); else passed++;
    checks++; if (bus.sram_web !== 1'b0) $display("FAIL single_web: got %b want 0", bus.sram_web); else passed++;
    checks++; if (bus.sram_d_in !== 32'hDEADBEEF) $display("FAIL single_d_in: got %h want deadbeef", bus.sram_d_in); else passed++;
    @(negedge clk);                       // cycle 1
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.sram_reb !== 1'b0) $display("FAIL single_reb: got %b want 0", bus.sram_reb); else passed++;
    checks++; if (bus.sram_addr_r !== 14'h0) $display("FAIL single_addr_r: got %h want 0000", bus.sram_addr_r); else passed++;
    checks++; if (bus.sram_csb !== 1'b0) $display("FAIL single_csb: got %b want 0", bus.sram_csb); else passed++;
    checks++; if (bus.count !== 10'd1) $display("FAIL single_count_c1: got %0d want 1", bus.count); else passed++;
    for (int c = 2; c < 4; c++) begin
      @(negedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_early_valid_c%0d: got %b want 0", c, bus.out_valid); else passed++;
    end
    @(negedge clk); #1;                   // cycle 4
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL single_valid_c4: got %b want 1", bus.out_valid); else passed++;
    checks++; if (bus.out_data !== 32'hDEADBEEF) $display("FAIL single_data: got %h want deadbeef", bus.out_data); else passed++;
    @(negedge clk); #1;                   // cycle 5
    checks++; if (bus.count !== 10'd0) $display("FAIL single_count_c5: got %0d want 0", bus.count); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_valid_c5: got %b want 0", bus.out_valid); else passed++;
  endtask

  task automatic test_fill();
    int k;
    int exp;
    int guard;
    k = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 560; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = k;
      #1;
      if (bus.in_ready) k++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checks++; if (k != 515) $display("FAIL fill_accepts: got %0d want 515", k); else passed++;
    checks++; if (bus.count !== 10'd515) $display("FAIL fill_count: got %0d want 515", bus.count); else passed++;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b want 0", bus.in_ready); else passed++;
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL fill_out_valid: got %b want 1", bus.out_valid); else passed++;
    exp = 0;
    guard = 0;
    while (exp < 515 && guard < 700) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      guard++;
      if (bus.out_valid) begin
        checks++; if (bus.out_data !== exp) $display("FAIL fill_drain_data: got %0d want %0d", bus.out_data, exp); else passed++;
        exp++;
      end
    end
    checks++; if (exp != 515) $display("FAIL fill_drain_total: got %0d want 515", exp); else passed++;
    @(negedge clk); #1;
    checks++; if (bus.count !== 10'd0) $display("FAIL fill_drain_count: got %0d want 0", bus.count); else passed++;
  endtask

  task automatic test_wrap_stream();
    int sent, rcvd, out_stalls, in_stalls, guard;
    bit saw_top, saw_wrap;
    logic [13:0] last_ra;
    sent = 0; rcvd = 0; out_stalls = 0; in_stalls = 0; guard = 0;
    saw_top = 1'b0; saw_wrap = 1'b0; last_ra = 14'h1;
    bus.out_ready = 1'b1;
    while (rcvd < 2000 && guard < 2200) begin
      @(negedge clk);
      bus.in_valid = (sent < 2000);
      bus.in_data  = 32'h1000_0000 + sent;
      #1;
      guard++;
      if (bus.in_valid) begin
        if (bus.in_ready) sent++;
        else in_stalls++;
      end
      if (!bus.sram_reb) begin
        if (bus.sram_addr_r == 14'h3FE0) saw_top = 1'b1;
        if (last_ra == 14'h3FE0 && bus.sram_addr_r == 14'h0000) saw_wrap = 1'b1;
        last_ra = bus.sram_addr_r;
      end
      if (bus.out_valid) begin
        checks++; if (bus.out_data !== 32'h1000_0000 + rcvd) $display("FAIL stream_data: got %h want %h", bus.out_data, 32'h1000_0000 + rcvd); else passed++;
        rcvd++;
      end else if (rcvd > 0) begin
        out_stalls++;
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (sent != 2000) $display("FAIL stream_sent: got %0d want 2000", sent); else passed++;
    checks++; if (rcvd != 2000) $display("FAIL stream_rcvd: got %0d want 2000", rcvd); else passed++;
    checks++; if (in_stalls != 0) $display("FAIL stream_in_stalls: got %0d want 0", in_stalls); else passed++;
    checks++; if (out_stalls != 0) $display("FAIL stream_out_bubbles: got %0d want 0", out_stalls); else passed++;
    checks++; if (!(saw_top && saw_wrap)) $display("FAIL stream_addr_wrap: got top=%0b wrap=%0b want 1 1", saw_top, saw_wrap); else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] q[$];
    int pushes;
    int in_pct, out_pct;
    pushes = 0;
    for (int c = 0; c < 10000; c++) begin
      if (c < 4000)      begin in_pct = 75; out_pct = 25; end
      else if (c < 7000) begin in_pct = 50; out_pct = 50; end
      else               begin in_pct = 25; out_pct = 75; end
      @(negedge clk);
      bus.in_valid  = ($urandom_range(0, 99) < in_pct);
      bus.out_ready = ($urandom_range(0, 99) < out_pct);
      bus.in_data   = $urandom;
      #1;
      checks++; if (bus.count !== q.size()) $display("FAIL bp_count cyc %0d: got %0d want %0d", c, bus.count, q.size()); else passed++;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) $display("FAIL bp_pop_empty cyc %0d: got data %h want no valid", c, bus.out_data);
        else if (bus.out_data !== q[0]) $display("FAIL bp_data cyc %0d: got %h want %h", c, bus.out_data, q[0]);
        else passed++;
        if (q.size() != 0) void'(q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(bus.in_data);
        pushes++;
      end
    end
    checks++; if (pushes < 1000) $display("FAIL bp_pushes: got %0d want >= 1000", pushes); else passed++;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    int k, guard;
    @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    k = 0; guard = 0;
    while (k < 105 && guard < 200) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = 32'hA000_0000 + k;
      #1;
      guard++;
      if (bus.in_ready) k++;
    end
    @(negedge clk); bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checks++; if (bus.count !== 10'd105) $display("FAIL midrst_pre_count: got %0d want 105", bus.count); else passed++;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      checks++; if (bus.sram_reb !== 1'b0) $display("FAIL midrst_issue%0d: got reb %b want 0", c, bus.sram_reb); else passed++;
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    checks++; if (bus.count !== 10'd103) $display("FAIL midrst_queued: got %0d want 103", bus.count); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b want 0", bus.in_ready); else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.count !== 10'd0) $display("FAIL midrst_count: got %0d want 0", bus.count); else passed++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_stale%0d: got valid %b want 0", c, bus.out_valid); else passed++;
    end
    @(negedge clk);                       // cycle P
    bus.in_valid = 1'b1; bus.in_data = 32'h1; bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.sram_addr_w !== 14'h0) $display("FAIL midrst_addr_w: got %h want 0000", bus.sram_addr_w); else passed++;
    @(negedge clk);                       // cycle P+1
    bus.in_valid = 1'b0;
    #1;
    checks++; if ({bus.sram_reb, bus.sram_addr_r} !== {1'b0, 14'h0}) $display("FAIL midrst_read: got reb %b addr %h want 0 0000", bus.sram_reb, bus.sram_addr_r); else passed++;
    repeat (3) @(negedge clk);            // cycle P+4
    #1;
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL midrst_new_valid: got %b want 1", bus.out_valid); else passed++;
    checks++; if (bus.out_data !== 32'h1) $display("FAIL midrst_new_data: got %h want 00000001", bus.out_data); else passed++;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++; if ({bus.out_valid, bus.count} !== {1'b0, 10'd0}) $display("FAIL midrst_alone%0d: got valid %b count %0d want 0 0", c, bus.out_valid, bus.count); else passed++;
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_wrap_stream();
    test_backpressure();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
